// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_pkg : shared opcodes, FSM encoding and special-case constants   |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q   = 32'h8000_0000;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG1    = 32'hFFFF_FFFF;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_iter : one shift-add multiply or restoring-divide step per en   |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            en,
  input  logic            is_div,
  input  logic [XLEN-1:0] load_hi,
  input  logic [XLEN-1:0] load_lo,
  input  logic [XLEN-1:0] load_m,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_ext;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;

  // Multiply: {hi,lo} is the product register, lo starts as the multiplier.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    w_sum     = lo_q[0] ? ({1'b0, hi_q} + {1'b0, m_q}) : {1'b0, hi_q};
    w_rem_ext = {hi_q, lo_q[XLEN-1]};
    w_ge      = (w_rem_ext >= {1'b0, m_q});
    // Remainder after a successful subtract is below the divisor, so it fits in XLEN bits
    w_sub     = w_rem_ext[XLEN-1:0] - m_q;
    if (load) begin
      hi_d = load_hi;
      lo_d = load_lo;
      m_d  = load_m;
    end else if (en) begin
      if (is_div) begin
        hi_d = w_ge ? w_sub : w_rem_ext[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], w_ge};
      end else begin
        hi_d = w_sum[XLEN:1];
        lo_d = {w_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu : iterative RV32M multiply/divide unit with register write-back |
// | Option : MDU_FAST_MUL_EN selects a single-cycle 33x33 multiplier    |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module mdu #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [4:0]      wr_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] wd,
  output logic [4:0]      wr,
  output logic            regwrite
);
  import mdu_pkg::*;

  localparam int              CNT_W    = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      idx_q, idx_d;
  logic            sign_q, sign_d, div0_q, div0_d, ovf_q, ovf_d, skip_q, skip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [4:0]      wr_q, wr_d;

  logic            w_sa, w_sb, w_neg_a, w_neg_b, w_div, w_div0, w_ovf, w_sign;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_ld_hi, w_ld_lo, w_ld_m;
  logic            w_it_load, w_it_en;
  logic [XLEN-1:0] w_it_hi, w_it_lo, w_quo_s, w_rem_s, w_result;
  logic [2*XLEN-1:0] w_prod_s;

  always_comb begin
    w_sa    = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
              (funct3 == F3_DIV)  || (funct3 == F3_REM);
    w_sb    = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    w_neg_a = w_sa & rd1[XLEN-1];
    w_neg_b = w_sb & rd2[XLEN-1];
    w_mag_a = w_neg_a ? -rd1 : rd1;
    w_mag_b = w_neg_b ? -rd2 : rd2;
    w_div   = is_div_op(funct3);
    w_div0  = w_div && (rd2 == '0);
    w_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (rd1 == INT_MIN) && (rd2 == NEG1);
    // A remainder takes the dividend's sign; products and quotients take the XOR
    w_sign  = (funct3 == F3_REM) ? w_neg_a : (w_neg_a ^ w_neg_b);
  end

`ifdef MDU_FAST_MUL_EN
  logic [XLEN:0]     w_ext_a, w_ext_b;
  logic [2*XLEN-1:0] w_fast;

  always_comb begin
    w_ext_a = {w_sa & rd1[XLEN-1], rd1};
    w_ext_b = {w_sb & rd2[XLEN-1], rd2};
    w_fast  = $signed({{(XLEN-1){w_ext_a[XLEN]}}, w_ext_a}) *
              $signed({{(XLEN-1){w_ext_b[XLEN]}}, w_ext_b});
  end
`endif

  always_comb begin
    w_ld_hi = '0;
    w_ld_lo = w_div ? w_mag_a : w_mag_b;
    w_ld_m  = w_div ? w_mag_b : w_mag_a;
`ifdef MDU_FAST_MUL_EN
    if (!w_div) begin
      w_ld_hi = w_fast[2*XLEN-1:XLEN];
      w_ld_lo = w_fast[XLEN-1:0];
      w_ld_m  = '0;
    end
`endif
  end

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (w_it_load),
    .en      (w_it_en),
    .is_div  (is_div_op(f3_q)),
    .load_hi (w_ld_hi),
    .load_lo (w_ld_lo),
    .load_m  (w_ld_m),
    .hi      (w_it_hi),
    .lo      (w_it_lo)
  );

  // On the special-case paths lo still holds |rd1|, which is what REM by zero returns
  always_comb begin
    w_prod_s = sign_q ? -{w_it_hi, w_it_lo} : {w_it_hi, w_it_lo};
    w_quo_s  = sign_q ? -w_it_lo : w_it_lo;
    w_rem_s  = sign_q ? -w_it_hi : w_it_hi;
    case (f3_q)
      F3_MUL:                        w_result = w_prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  w_result = w_prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               w_result = div0_q ? DIV0_Q : (ovf_q ? OVF_Q : w_quo_s);
      default:                       w_result = div0_q ? w_quo_s : (ovf_q ? '0 : w_rem_s);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    idx_d     = idx_q;
    sign_d    = sign_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    skip_d    = skip_q;
    cnt_d     = cnt_q;
    wd_d      = wd_q;
    wr_d      = wr_q;
    w_it_load = 1'b0;
    w_it_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d      = funct3;
          idx_d     = wr_in;
          sign_d    = w_sign;
          div0_d    = w_div0;
          ovf_d     = w_ovf;
          skip_d    = w_div0 | w_ovf;
          cnt_d     = '0;
          w_it_load = 1'b1;
          state_d   = S_CALC;
`ifdef MDU_FAST_MUL_EN
          if (!w_div) begin
            sign_d = 1'b0;
            skip_d = 1'b1;
          end
`endif
        end
      end
      S_CALC: begin
        if (skip_q) begin
          state_d = S_FIX;
        end else begin
          w_it_en = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        wd_d    = w_result;
        wr_d    = idx_q;
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      idx_q   <= '0;
      sign_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      skip_q  <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      idx_q   <= idx_d;
      sign_q  <= sign_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      wr_q    <= wr_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_WB);
  assign regwrite = (state_q == S_WB) && (wr_q != 5'd0);
  assign wd       = wd_q;
  assign wr       = wr_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mdu : directed self-checking bench for the mdu multiply/divide   |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rd1, rd2;
  logic [4:0]  wr_in;
  logic        busy, done, regwrite;
  logic [31:0] wd;
  logic [4:0]  wr;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int ML = 3;
`else
  localparam int ML = 34;
`endif
  localparam int DL = 34;
  localparam int FL = 3;

  mdu #(.XLEN(32), .ITER(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rd1      (rd1),
    .rd2      (rd2),
    .wr_in    (wr_in),
    .busy     (busy),
    .done     (done),
    .wd       (wd),
    .wr       (wr),
    .regwrite (regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge 1 is the edge that samples start; outputs are observed 1 time unit after each edge.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] idx,
                        input logic [31:0] exp_wd, input int lat, input int poke_at);
    int edges, done_edge, rw_edge, n_done;
    logic [31:0] got_wd;
    logic [4:0]  got_wr;
    funct3 = f3; rd1 = a; rd2 = b; wr_in = idx; start = 1'b1;
    tick();
    edges = 1;
    start = 1'b0;
    rd1 = $urandom; rd2 = $urandom; funct3 = 3'($urandom); wr_in = 5'($urandom);
    done_edge = 0; rw_edge = 0; n_done = 0; got_wd = '0; got_wr = '0;
    while (busy && edges < 200) begin
      if (done) begin
        n_done++;
        done_edge = edges;
        got_wd = wd;
        got_wr = wr;
      end
      if (regwrite) rw_edge = edges;
      start = (edges == poke_at);
      tick();
      edges++;
    end
    start = 1'b0;
    check({tag, "_wd"},    got_wd, exp_wd);
    check({tag, "_wr"},    32'(got_wr), 32'(idx));
    check({tag, "_done"},  32'(done_edge), 32'(lat));
    check({tag, "_ndone"}, 32'(n_done), 32'd1);
    check({tag, "_rw"},    32'(rw_edge), (idx != 5'd0) ? 32'(lat) : 32'd0);
    check({tag, "_idle"},  32'(edges), 32'(lat + 1));
    tick();
    check({tag, "_stay"},  32'(busy), 32'd0);
    check({tag, "_hold"},  wd, exp_wd);
  endtask

  initial begin
    int n_rw;
    reset = 1'b1; start = 1'b0; funct3 = '0; rd1 = '0; rd2 = '0; wr_in = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rw",   32'(regwrite), 32'd0);
    check("rst_wd",   wd, 32'd0);
    check("rst_wr",   32'(wr), 32'd0);

    run_op("mul",      F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, ML, 0);
    run_op("mulh",     F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, ML, 0);
    run_op("mulhu",    F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, ML, 0);
    run_op("mulhsu",   F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, ML, 0);
    run_op("mulh_neg", F3_MULH,   32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF, ML, 0);
    run_op("div",      F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFD, DL, 0);
    run_op("rem",      F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFF, DL, 0);
    run_op("div_nb",   F3_DIV,    32'd20,         32'hFFFF_FFFD, 5'd8,  32'hFFFF_FFFA, DL, 0);
    run_op("rem_nb",   F3_REM,    32'd20,         32'hFFFF_FFFD, 5'd9,  32'd2,         DL, 0);
    run_op("divu",     F3_DIVU,   32'd100,        32'd7,         5'd10, 32'h0000_000E, DL, 0);
    run_op("remu",     F3_REMU,   32'd100,        32'd7,         5'd11, 32'h0000_0002, DL, 34);
    run_op("div0",     F3_DIV,    32'd5,          32'd0,         5'd12, 32'hFFFF_FFFF, FL, 0);
    run_op("remu0",    F3_REMU,   32'd5,          32'd0,         5'd13, 32'h0000_0005, FL, 0);
    run_op("rem0_neg", F3_REM,    32'hFFFF_FFF0,  32'd0,         5'd14, 32'hFFFF_FFF0, FL, 0);
    run_op("div_ovf",  F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, FL, 0);
    run_op("rem_ovf",  F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         FL, 0);
    run_op("mul_x0",   F3_MUL,    32'd3,          32'd4,         5'd0,  32'h0000_000C, ML, 0);
    run_op("mul_poke", F3_MUL,    32'd6,          32'd7,         5'd17, 32'h0000_002A, ML, (ML > 10) ? 10 : 2);
    run_op("divu_max", F3_DIVU,   32'hFFFF_FFFF,  32'h8000_0001, 5'd18, 32'd1,         DL, 0);
    run_op("remu_max", F3_REMU,   32'hFFFF_FFFF,  32'h8000_0001, 5'd19, 32'h7FFF_FFFE, DL, 0);

    // Reset in the middle of a divide must abort with no write strobe
    funct3 = F3_DIV; rd1 = 32'd1000; rd2 = 32'd3; wr_in = 5'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wd",   wd, 32'd0);
    check("abort_wr",   32'(wr), 32'd0);
    n_rw = 0;
    repeat (40) begin
      if (regwrite || done) n_rw++;
      tick();
    end
    check("abort_norw", 32'(n_rw), 32'd0);

    run_op("post_rst", F3_DIVU,   32'd9,          32'd3,         5'd20, 32'd3,         DL, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
